// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Data-memory end of the load/store path: byte/half/word access to
//            a word-organised RAM with WAIT_CYC wait states and a response pulse.
//            Optional misalignment/illegal-func3 checking via DMEM_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_depth     = 1 << ADDR_W;
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_after_accept = (WAIT_CYC > 0) ? c_st_wait : c_st_access;
    localparam logic [3:0] c_wait_last = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [2:0]        r_func3;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_mem [0:c_depth-1];

    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_lane;
    logic              w_is_byte;
    logic              w_is_half;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_pos;
    logic [31:0]       w_rword;
    logic [7:0]        w_rbyte;
    logic [15:0]       w_rhalf;
    logic [31:0]       w_load;
    logic              w_err;
    logic              w_mem_we;
    logic              w_unused;

    // Upper address bits wrap the address space onto the RAM.
    assign w_unused = &{1'b0, req_addr[31:ADDR_W+2]};

    assign req_ready = (r_state == c_st_idle);
    assign w_idx     = r_addr[ADDR_W+1:2];
    assign w_lane    = r_addr[1:0];

    // Store-side 100/101 are not byte/half ops, so they fall through to word.
    assign w_is_byte = (r_func3 == 3'b000) | (!r_we & (r_func3 == 3'b100));
    assign w_is_half = (r_func3 == 3'b001) | (!r_we & (r_func3 == 3'b101));

`ifdef DMEM_ALIGN_CHECK_EN
    logic w_illegal;
    assign w_illegal = (r_func3 == 3'b011) | (r_func3[2:1] == 2'b11) | (r_we & r_func3[2]);
    assign w_err     = w_illegal
                     | (w_is_half & w_lane[0])
                     | ((r_func3 == 3'b010) & (w_lane != 2'b00));
`else
    assign w_err = 1'b0;
`endif

    always_comb begin
        w_be        = 4'b1111;
        w_wdata_pos = r_wdata;
        if (w_is_byte) begin
            w_be        = 4'b0001 << w_lane;
            w_wdata_pos = {4{r_wdata[7:0]}};
        end else if (w_is_half) begin
            w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata_pos = {2{r_wdata[15:0]}};
        end
    end

    assign w_rword = r_mem[w_idx];
    assign w_rbyte = w_rword[8*w_lane +: 8];
    assign w_rhalf = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_load = w_rword;
        if (w_is_byte) begin
            w_load = r_func3[2] ? {24'd0, w_rbyte} : {{24{w_rbyte[7]}}, w_rbyte};
        end else if (w_is_half) begin
            w_load = r_func3[2] ? {16'd0, w_rhalf} : {{16{w_rhalf[15]}}, w_rhalf};
        end
    end

    assign w_mem_we = (r_state == c_st_access) & r_we & ~w_err;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_pos[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_func3   <= 3'd0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_func3 <= req_func3;
                        r_addr  <= req_addr[ADDR_W+1:0];
                        r_wdata <= req_wdata;
                        r_cnt   <= 4'd0;
                        r_state <= c_st_after_accept;
                    end
                end
                c_st_wait: begin
                    if (r_cnt == c_wait_last) begin
                        r_cnt   <= 4'd0;
                        r_state <= c_st_access;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_st_access: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= w_err;
                    if (!r_we) begin
                        rsp_rdata <= w_err ? 32'd0 : w_load;
                    end
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule

`default_nettype wire
